// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter sharing one combinational ALU
//
// Purpose:
//   Accepts one operation at a time from two requesters, latches the winner's
//   operands/opcode onto the ALU inputs, registers the ALU result after one
//   execute cycle, and returns it with the requester ID on a valid/ready channel.
//   Each operation takes at least three cycles: IDLE (accept), EXEC, RESP.
//
// Configuration:
//   ARB_RR_EN defined   : round-robin between requesters when both are valid.
//   ARB_RR_EN undefined : fixed priority, req0 wins contention.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/req0_ready     requester 0 handshake (ready only in IDLE)
//   req0_v1/req0_v2/req0_instr requester 0 operands and opcode
//   req1_*                    same for requester 1
//   alu_v1/alu_v2/alu_instructions  latched operands/opcode to the ALU
//   alu_result                ALU output (combinational in the ALU)
//   resp_valid/resp_ready     response handshake
//   resp_data/resp_id         registered result and issuing requester
//   busy                      an operation is in flight
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_v1,
  input  logic [XLEN-1:0] req0_v2,
  input  logic [OPW-1:0]  req0_instr,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_v1,
  input  logic [XLEN-1:0] req1_v2,
  input  logic [OPW-1:0]  req1_instr,
  output logic [XLEN-1:0] alu_v1,
  output logic [XLEN-1:0] alu_v2,
  output logic [OPW-1:0]  alu_instructions,
  input  logic [XLEN-1:0] alu_result,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_id,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;
  logic   accept;
  logic   grant_id;

`ifdef ARB_RR_EN
  // Requester favoured on the next contended grant; 0 after reset.
  logic   favour;
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
`ifdef ARB_RR_EN
    grant_id   = (req0_valid && req1_valid) ? favour : ~req0_valid;
`else
    grant_id   = ~req0_valid;
`endif
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_next = EXEC;
          accept     = 1'b1;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A cycle with reset asserted never accepts, so ready must not be shown.
    if (rst) accept = 1'b0;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      alu_v1           <= '0;
      alu_v2           <= '0;
      alu_instructions <= '0;
      resp_data        <= '0;
      resp_id          <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        alu_v1           <= grant_id ? req1_v1    : req0_v1;
        alu_v2           <= grant_id ? req1_v2    : req0_v2;
        alu_instructions <= grant_id ? req1_instr : req0_instr;
        resp_id          <= grant_id;
      end
      if (state == EXEC) resp_data <= alu_result;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)         favour <= 1'b0;
    else if (accept) favour <= ~grant_id;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  localparam int XLEN = 32;
  localparam int OPW  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [XLEN-1:0] req0_v1, req0_v2, req1_v1, req1_v2;
  logic [OPW-1:0]  req0_instr, req1_instr;
  logic [XLEN-1:0] alu_v1, alu_v2, alu_result, resp_data;
  logic [OPW-1:0]  alu_instructions;
  logic            resp_valid, resp_ready, resp_id, busy;

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [OPW-1:0] op);
    return (a + b) ^ {{(XLEN-OPW){1'b0}}, op};
  endfunction

  assign alu_result = alu_fn(alu_v1, alu_v2, alu_instructions);

  alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_v1(req0_v1), .req0_v2(req0_v2), .req0_instr(req0_instr),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_v1(req1_v1), .req1_v2(req1_v2), .req1_instr(req1_instr),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_instructions(alu_instructions),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one operation in flight, identified by the
  // number of edges since it was accepted (1 = executing, 2 = responding).
  bit              started = 1'b0;
  bit              m_busy, m_fav, m_id;
  int              m_age;
  logic [XLEN-1:0] m_v1, m_v2, m_data;
  logic [OPW-1:0]  m_op;
  logic            g_id, g_any;

  always @(negedge clk) begin
    g_any = req0_valid || req1_valid;
    g_id  = (req0_valid && req1_valid) ? m_fav : !req0_valid;
    if (started) begin
      check("busy",       busy,       m_busy);
      check("resp_valid", resp_valid, m_busy && m_age == 2);
      check("req0_ready", req0_ready, !rst && !m_busy && g_any && !g_id);
      check("req1_ready", req1_ready, !rst && !m_busy && g_any && g_id);
      check("alu_v1",     alu_v1,     m_v1);
      check("alu_v2",     alu_v2,     m_v2);
      check("alu_instr",  alu_instructions, m_op);
      check("resp_id",    resp_id,    m_id);
      check("resp_data",  resp_data,  m_data);
    end
    if (rst) begin
      started = 1'b1;
      m_busy = 0; m_fav = 0; m_id = 0; m_age = 0;
      m_v1 = '0; m_v2 = '0; m_op = '0; m_data = '0;
    end else if (!m_busy) begin
      if (g_any) begin
        m_busy = 1; m_age = 1; m_id = g_id;
        m_v1 = g_id ? req1_v1    : req0_v1;
        m_v2 = g_id ? req1_v2    : req0_v2;
        m_op = g_id ? req1_instr : req0_instr;
`ifdef ARB_RR_EN
        m_fav = !g_id;
`endif
      end
    end else if (m_age == 1) begin
      m_data = alu_fn(m_v1, m_v2, m_op);
      m_age  = 2;
    end else if (resp_ready) begin
      m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  int grants[4];
  int exp_g[4];
  int ng;
  bit got;

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_v1 = 0; req0_v2 = 0; req0_instr = 0;
    req1_v1 = 0; req1_v2 = 0; req1_instr = 0;

    // Reset values
    tick(); tick();
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_busy",       busy,       0);
    check("rst_alu_v1",     alu_v1,     0);

    // Single operation from requester 0
    tick();
    rst = 0; req0_valid = 1; req0_v1 = 5; req0_v2 = 4; req0_instr = 10'h1; resp_ready = 1;
    @(negedge clk);
    check("single_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("single_exec_v1",    alu_v1, 5);
    check("single_exec_v2",    alu_v2, 4);
    check("single_exec_rv",    resp_valid, 0);
    tick();
    @(negedge clk);
    check("single_resp_valid", resp_valid, 1);
    check("single_resp_data",  resp_data, 8);
    check("single_resp_id",    resp_id, 0);
    tick();

    // Contention from a fresh reset
    rst = 1; tick(); tick(); rst = 0;
    req0_valid = 1; req0_v1 = 32'h10; req0_v2 = 32'h20; req0_instr = 10'h3;
    req1_valid = 1; req1_v1 = 32'h111; req1_v2 = 32'h222; req1_instr = 10'h5;
    ng = 0;
    for (int i = 0; i < 30 && ng < 4; i++) begin
      @(negedge clk);
      if (req0_ready) begin grants[ng] = 0; ng++; end
      else if (req1_ready) begin grants[ng] = 1; ng++; end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    check("contention_grant_count", ng, 4);
`ifdef ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
    for (int i = 0; i < 4; i++) check($sformatf("contention_grant%0d", i), grants[i], exp_g[i]);
    tick(); tick(); tick();

    // Backpressure holds the response and blocks requester 1
    rst = 1; tick(); rst = 0;
    resp_ready = 0; req0_valid = 1; req0_v1 = 100; req0_v2 = 23; req0_instr = 10'h3;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
      tick();
    end
    check("bp_accept_seen", got, 1);
    req0_valid = 0; req1_valid = 1; req1_v1 = 7; req1_v2 = 9; req1_instr = 10'h0;
    @(negedge clk);
    check("bp_exec_req1_ready", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_resp_valid", resp_valid, 1);
      check("bp_hold_resp_data",  resp_data, 120);
      check("bp_hold_resp_id",    resp_id, 0);
      check("bp_hold_req1_ready", req1_ready, 0);
      tick();
    end
    resp_ready = 1;
    @(negedge clk);
    check("bp_handshake_req1_ready", req1_ready, 0);
    tick();
    @(negedge clk);
    check("bp_after_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick(); tick(); tick();

    // Reset during EXEC drops the operation
    req0_valid = 1; req0_v1 = 1; req0_v2 = 2; req0_instr = 10'h7;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
      tick();
    end
    check("rstexec_accept_seen", got, 1);
    req0_valid = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("rstexec_busy",       busy, 0);
    check("rstexec_resp_valid", resp_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("rstexec_no_resp", resp_valid, 0);
    end
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 1) == 1;
      req0_v1    = $urandom; req0_v2 = $urandom; req0_instr = OPW'($urandom_range(0, 1023));
      req1_v1    = $urandom; req1_v2 = $urandom; req1_instr = OPW'($urandom_range(0, 1023));
      resp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    rst = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
    tick(); tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
